pattern_datapath: RTL and testbench



---
 rtl/game_pkg.sv | 26 ++
 rtl/lfsr_gen.sv | 35 +++
 rtl/pattern_datapath.sv | 164 ++++++++++++++++
 tb/tb_pattern_datapath.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants, state encoding and LFSR helper for the pattern game datapath.
package game_pkg;

    localparam int GAME_DEPTH        = 16;
    localparam int GAME_ADDR_W       = 4;
    localparam int GAME_WIDTH        = 2;
    localparam int GAME_TIMER_CYCLES = 5;
    localparam int GAME_ROUND_W      = 5;

    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps on bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        COMMIT,
        LOST
    } state_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// 8-bit pattern LFSR; built only when PATTERN_LFSR_EN is defined.
`ifdef PATTERN_LFSR_EN
module lfsr_gen
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (clear) begin
            lfsr_d = LFSR_SEED;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule
`endif

// File: rtl/pattern_datapath.sv
// Pattern store/verify datapath beside the game controller.
// Define PATTERN_LFSR_EN to store LFSR symbols instead of dataIn on loads.
module pattern_datapath
    import game_pkg::*;
#(
    parameter int DEPTH        = GAME_DEPTH,
    parameter int ADDR_W       = GAME_ADDR_W,
    parameter int WIDTH        = GAME_WIDTH,
    parameter int TIMER_CYCLES = GAME_TIMER_CYCLES,
    parameter int ROUND_W      = GAME_ROUND_W
) (
    input  logic               clka,
    input  logic               reset,
    input  logic               loadData,
    input  logic               readData,
    input  logic               writeData,
    input  logic               writeout,
    input  logic               restart,
    input  logic [ADDR_W-1:0]  count,
    input  logic [WIDTH-1:0]   dataIn,
    input  logic [WIDTH-1:0]   playerIn,
    input  logic               playerValid,
    output logic [WIDTH-1:0]   dataOut,
    output logic               loseSig,
    output logic               timer5,
    output logic [ROUND_W-1:0] roundLen
);

    localparam int CNT_W = (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMER_CYCLES - 1);
    localparam logic [ROUND_W-1:0] ROUND_MAX = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               lose_q, lose_d;
    logic               timer5_q, timer5_d;
    logic [ROUND_W-1:0] round_q, round_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             in_range;
    logic             load_en;
    logic             read_en;
    logic             mismatch;
    logic             idle_cycle;
    logic [WIDTH-1:0] mem_rd;
    logic [WIDTH-1:0] store_sym;

    // restart outranks loadData, which outranks readData.
    assign in_range   = (int'(count) < DEPTH);
    assign load_en    = loadData & writeData & ~restart;
    assign read_en    = readData & writeData & ~loadData & ~restart;
    assign mem_rd     = in_range ? mem[count] : '0;
    assign mismatch   = read_en & playerValid & (playerIn != mem_rd);
    assign idle_cycle = ~loadData & ~readData & ~writeout & ~restart & (state_q != LOST);

`ifdef PATTERN_LFSR_EN
    logic [7:0] lfsr_val;
    logic       unused_bits;

    lfsr_gen u_lfsr (
        .clk     (clka),
        .rst     (reset),
        .clear   (restart),
        .advance (load_en),
        .value   (lfsr_val)
    );

    assign store_sym   = lfsr_val[WIDTH-1:0];
    assign unused_bits = ^{dataIn, lfsr_val[7:WIDTH]};
`else
    assign store_sym = dataIn;
`endif

    always_ff @(posedge clka) begin
        if (load_en && in_range) begin
            mem[count] <= store_sym;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        data_out_d = data_out_q;
        lose_d     = lose_q;
        timer5_d   = 1'b0;
        round_d    = round_q;

        if (restart) begin
            state_d    = IDLE;
            idle_cnt_d = '0;
            data_out_d = '0;
            lose_d     = 1'b0;
            round_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_en) begin
                        state_d = LOAD;
                    end else if (read_en) begin
                        state_d = VERIFY;
                    end
                end
                LOAD, VERIFY: begin
                    if (writeout) begin
                        state_d = COMMIT;
                    end
                end
                COMMIT:  state_d = IDLE;
                LOST:    state_d = LOST;
                default: state_d = IDLE;
            endcase

            if (read_en) begin
                data_out_d = mem_rd;
            end

            if (mismatch) begin
                lose_d  = 1'b1;
                state_d = LOST;
            end

            if (writeout && (state_q != LOST) && (round_q != ROUND_MAX)) begin
                round_d = round_q + 1'b1;
            end

            if (idle_cycle) begin
                if (idle_cnt_q == CNT_LAST) begin
                    timer5_d   = 1'b1;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end else begin
                idle_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
            data_out_q <= '0;
            lose_q     <= 1'b0;
            timer5_q   <= 1'b0;
            round_q    <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            data_out_q <= data_out_d;
            lose_q     <= lose_d;
            timer5_q   <= timer5_d;
            round_q    <= round_d;
        end
    end

    assign dataOut  = data_out_q;
    assign loseSig  = lose_q;
    assign timer5   = timer5_q;
    assign roundLen = round_q;

endmodule

// File: tb/tb_pattern_datapath.sv
// Scoreboard bench for pattern_datapath: stimulus queues expectations, a monitor checks them.
module tb_pattern_datapath;

    logic       clka = 1'b0;
    logic       reset;
    logic       loadData, readData, writeData, writeout, restart, playerValid;
    logic [3:0] count;
    logic [1:0] dataIn, playerIn;
    logic [1:0] dataOut;
    logic       loseSig, timer5;
    logic [4:0] roundLen;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] M_D = 4'b0001;
    localparam logic [3:0] M_L = 4'b0010;
    localparam logic [3:0] M_T = 4'b0100;
    localparam logic [3:0] M_R = 4'b1000;
    localparam logic [3:0] M_A = 4'b1111;

    localparam logic [1:0] DATA [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
`ifdef PATTERN_LFSR_EN
    // Low two bits of A5, 4A, 95, 2A: successive LFSR states from the seed.
    localparam logic [1:0] SYM [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
    localparam logic [1:0] S5A = 2'd1;
`else
    localparam logic [1:0] SYM [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    localparam logic [1:0] S5A = 2'd3;
`endif

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [1:0] dout;
        logic       lose;
        logic       t5;
        logic [4:0] rlen;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;

    always #5 clka = ~clka;

    pattern_datapath dut (
        .clka        (clka),
        .reset       (reset),
        .loadData    (loadData),
        .readData    (readData),
        .writeData   (writeData),
        .writeout    (writeout),
        .restart     (restart),
        .count       (count),
        .dataIn      (dataIn),
        .playerIn    (playerIn),
        .playerValid (playerValid),
        .dataOut     (dataOut),
        .loseSig     (loseSig),
        .timer5      (timer5),
        .roundLen    (roundLen)
    );

    task automatic check_field(input string nm, input string fld, input logic [4:0] got,
                               input logic [4:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, got, want);
        end
    endtask

    always begin
        @(negedge clka or chk_ev);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.mask[0]) check_field(e.name, "dataOut",  {3'b0, dataOut}, {3'b0, e.dout});
            if (e.mask[1]) check_field(e.name, "loseSig",  {4'b0, loseSig}, {4'b0, e.lose});
            if (e.mask[2]) check_field(e.name, "timer5",   {4'b0, timer5},  {4'b0, e.t5});
            if (e.mask[3]) check_field(e.name, "roundLen", roundLen, e.rlen);
            $display("check %s: dout=%0d lose=%0d t5=%0d round=%0d", e.name, dataOut, loseSig,
                     timer5, roundLen);
        end
    end

    task automatic push_exp(input string nm, input logic [3:0] msk, input logic [1:0] ed,
                            input logic el, input logic et, input logic [4:0] er);
        exp_t e;
        e.name = nm; e.mask = msk; e.dout = ed; e.lose = el; e.t5 = et; e.rlen = er;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; the expectation describes outputs after this edge.
    task automatic cyc(input string nm, input logic ld, input logic rd, input logic wd,
                       input logic wo, input logic rs, input logic [3:0] cnt,
                       input logic [1:0] din, input logic [1:0] pin, input logic pv,
                       input logic [3:0] msk, input logic [1:0] ed, input logic el,
                       input logic et, input logic [4:0] er);
        loadData = ld; readData = rd; writeData = wd; writeout = wo; restart = rs;
        count = cnt; dataIn = din; playerIn = pin; playerValid = pv;
        @(posedge clka);
        if (msk != 4'b0) push_exp(nm, msk, ed, el, et, er);
        #1;
    endtask

    task automatic idle_inputs();
        loadData = 0; readData = 0; writeData = 0; writeout = 0; restart = 0;
        count = 0; dataIn = 0; playerIn = 0; playerValid = 0;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clka);
        #1;
        reset = 1'b1;
        idle_inputs();
        #1;
        push_exp(nm, M_A, 2'd0, 1'b0, 1'b0, 5'd0);
        -> chk_ev;
        @(posedge clka);
        @(posedge clka);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clka);
        #1;
        push_exp("reset_state", M_A, 2'd0, 1'b0, 1'b0, 5'd0);
        -> chk_ev;
        @(posedge clka);
        #1;
        reset = 1'b0;

        // Load then verify a matching sequence.
        for (int i = 0; i < 4; i++)
            cyc("load", 1, 0, 1, 0, 0, 4'(i), DATA[i], 0, 0, M_L | M_R | M_T, 0, 0, 0, 0);
        cyc("commit_load", 0, 0, 0, 1, 0, 0, 0, 0, 0, M_L | M_R | M_T, 0, 0, 0, 1);
        cyc("restart1", 0, 0, 0, 0, 1, 0, 0, 0, 0, M_A, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc("verify", 0, 1, 1, 0, 0, 4'(i), 0, SYM[i], 1, M_A, SYM[i], 0, 0, 0);
        cyc("commit_verify", 0, 0, 0, 1, 0, 0, 0, 0, 0, M_D | M_L | M_R, SYM[3], 0, 0, 1);

        // Mismatch: sticky loseSig, no commit while lost, restart clears.
        cyc("mismatch", 0, 1, 1, 0, 0, 4'd2, 0, 2'd0, 1, M_A, SYM[2], 1, 0, 1);
        cyc("lost_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, M_L | M_R | M_T, 0, 1, 0, 1);
        cyc("lost_commit", 0, 0, 0, 1, 0, 0, 0, 0, 0, M_L | M_R, 0, 1, 0, 1);
        cyc("restart2", 0, 0, 0, 0, 1, 0, 0, 0, 0, M_A, 0, 0, 0, 0);
        cyc("commit_after_rst", 0, 0, 0, 1, 0, 0, 0, 0, 0, M_L | M_R, 0, 0, 0, 1);

        // Strobe priority.
        cyc("load5", 1, 0, 1, 0, 0, 4'd5, 2'd3, 0, 0, M_L, 0, 0, 0, 1);
        cyc("read5_a", 0, 1, 1, 0, 0, 4'd5, 0, S5A, 1, M_D | M_L, S5A, 0, 0, 1);
        cyc("pv_no_read", 0, 0, 1, 0, 0, 4'd5, 0, S5A ^ 2'd1, 1, M_L, 0, 0, 0, 1);
        cyc("ld_rd_both", 1, 1, 1, 0, 0, 4'd5, 2'd2, 2'd0, 1, M_D | M_L, S5A, 0, 0, 1);
        cyc("read5_b", 0, 1, 1, 0, 0, 4'd5, 0, 2'd2, 1, M_D | M_L, 2'd2, 0, 0, 1);
        cyc("restart_ld", 1, 0, 1, 0, 1, 4'd5, 2'd1, 0, 0, M_A, 0, 0, 0, 0);
        cyc("read5_c", 0, 1, 1, 0, 0, 4'd5, 0, 2'd2, 1, M_D | M_L | M_R, 2'd2, 0, 0, 0);
        cyc("commit_idle", 0, 0, 0, 1, 0, 0, 0, 0, 0, M_R, 0, 0, 0, 1);
        cyc("mismatch5", 0, 1, 1, 0, 0, 4'd5, 0, 2'd3, 1, M_A, 2'd2, 1, 0, 1);

        // Asynchronous reset between edges while outputs are non-zero.
        do_reset("async_reset");

        // Idle timer: pulses after edges 5 and 10.
        for (int k = 1; k <= 12; k++)
            cyc("timer_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, M_T | M_L | M_R, 0, 0,
                (k == 5 || k == 10), 0);

        do_reset("reset2");
        // Load at cycle 7 restarts the count; next pulse at cycle 12.
        for (int k = 1; k <= 13; k++)
            cyc("timer_load", (k == 7), 0, (k == 7), 0, 0, 4'd9, 2'd1, 0, 0, M_T, 0, 0,
                (k == 5 || k == 12), 0);

        // Round counter saturation.
        for (int i = 1; i <= 40; i++)
            cyc("saturate", 0, 0, 0, 1, 0, 0, 0, 0, 0, M_R | M_T, 0, 0, 0,
                (i > 31) ? 5'd31 : 5'(i));

        idle_inputs();
        repeat (2) @(posedge clka);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
